// File: rtl/gb_bist_master.sv
// gb_bist_master
//   In-fabric ghostbus write/read-back self-test engine. Walks the address
//   window base_addr .. base_addr+count-1 (wrapping mod 2^AW), writes the
//   pattern seed+i, reads each word back, compares it under dmask and logs
//   mismatches.
//
// Ports
//   gb_clk, gb_arst_n   bus clock (rising edge), async active-low reset
//   start, abort        one-cycle control pulses (abort wins)
//   mode                0 write-only, 1 read-check, 2 write then read-check,
//                       3 behaves as 1
//   base_addr, count    address window
//   seed, dmask         pattern seed, compare mask (1 = bit checked)
//   busy, done, pass    run status; pass is meaningful while done=1
//   err_count           saturating mismatch counter
//   first_err_addr/data address and raw read data of the first mismatch
//   gb_addr, gb_wdata   bus address / write data (held between strobes)
//   gb_wen, gb_rstb     write / read strobes, never active together
//   gb_rdata            read data, valid RD_LAT cycles after gb_rstb
module gb_bist_master #(
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned ECW    = 16
) (
    input  logic          gb_clk,
    input  logic          gb_arst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] count,
    input  logic [DW-1:0] seed,
    input  logic [DW-1:0] dmask,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [ECW-1:0] err_count,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_data,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata
);

    localparam int unsigned WCW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    // WAIT lasts RD_LAT-1 cycles; the counter runs from RD_LAT-2 down to 0.
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [WCW-1:0] W_ONE     = WCW'(1);
    localparam logic [AW-1:0]  A_ONE     = AW'(1);
    localparam logic [DW-1:0]  D_ONE     = DW'(1);
    localparam logic [ECW-1:0] E_ONE     = ECW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_CHK,
        S_DONE
    } state_t;

    state_t         state;
    logic [1:0]     rst_sync;
    logic           rst_n_int;
    logic           r_read;
    logic [AW-1:0]  r_base;
    logic [AW-1:0]  r_count;
    logic [DW-1:0]  r_seed;
    logic [DW-1:0]  r_dmask;
    logic [AW-1:0]  idx;
    logic [WCW-1:0] wait_cnt;

    logic           last_word;
    logic [AW-1:0]  cur_addr;
    logic [AW-1:0]  next_addr;
    logic [DW-1:0]  cur_pat;
    logic [DW-1:0]  next_pat;
    logic           mismatch;
    logic [ECW-1:0] err_next;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge gb_clk or negedge gb_arst_n) begin
        if (!gb_arst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    always_comb begin
        last_word = (idx == (r_count - A_ONE));
        cur_addr  = r_base + idx;
        next_addr = cur_addr + A_ONE;
        cur_pat   = r_seed + DW'(idx);
        next_pat  = cur_pat + D_ONE;
        mismatch  = ((gb_rdata ^ cur_pat) & r_dmask) != '0;
        err_next  = err_count;
        if (mismatch && (err_count != '1)) begin
            err_next = err_count + E_ONE;
        end
    end

    always_ff @(posedge gb_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            gb_addr        <= '0;
            gb_wdata       <= '0;
            gb_wen         <= 1'b0;
            gb_rstb        <= 1'b0;
            r_read         <= 1'b0;
            r_base         <= '0;
            r_count        <= '0;
            r_seed         <= '0;
            r_dmask        <= '0;
            idx            <= '0;
            wait_cnt       <= '0;
        end else if (abort && busy) begin
            // Cancel: strobes drop, status cleared, error log retained.
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            gb_wen  <= 1'b0;
            gb_rstb <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        r_read         <= (mode != 2'd0);
                        r_base         <= base_addr;
                        r_count        <= count;
                        r_seed         <= seed;
                        r_dmask        <= dmask;
                        idx            <= '0;
                        if (count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else if ((mode == 2'd0) || (mode == 2'd2)) begin
                            state    <= S_WR;
                            busy     <= 1'b1;
                            gb_wen   <= 1'b1;
                            gb_addr  <= base_addr;
                            gb_wdata <= seed;
                        end else begin
                            state   <= S_RD;
                            busy    <= 1'b1;
                            gb_rstb <= 1'b1;
                            gb_addr <= base_addr;
                        end
                    end
                end

                S_WR: begin
                    if (last_word) begin
                        gb_wen <= 1'b0;
                        idx    <= '0;
                        if (r_read) begin
                            state   <= S_RD;
                            gb_rstb <= 1'b1;
                            gb_addr <= r_base;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0);
                        end
                    end else begin
                        idx      <= idx + A_ONE;
                        gb_addr  <= next_addr;
                        gb_wdata <= next_pat;
                    end
                end

                S_RD: begin
                    gb_rstb <= 1'b0;
                    if (RD_LAT > 1) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state <= S_CHK;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_CHK;
                    end else begin
                        wait_cnt <= wait_cnt - W_ONE;
                    end
                end

                S_CHK: begin
                    err_count <= err_next;
                    if (mismatch && (err_count == '0)) begin
                        first_err_addr <= cur_addr;
                        first_err_data <= gb_rdata;
                    end
                    if (last_word) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Use the post-update count so a miss on the last word is seen.
                        pass  <= (err_next == '0);
                    end else begin
                        idx     <= idx + A_ONE;
                        state   <= S_RD;
                        gb_rstb <= 1'b1;
                        gb_addr <= next_addr;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gb_bist_master.sv
// tb_gb_bist_master
//   Bench for gb_bist_master: a RAM slave with RD_LAT read latency and a
//   per-address fault map, a run-level reference model that predicts bus
//   events (kind, address, data, cycle offset from start) and final status,
//   and a monitor that pops and compares those predictions as the DUT acts.
module tb_gb_bist_master;

    localparam int unsigned AW     = 24;
    localparam int unsigned DW     = 32;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned ECW    = 16;

    logic           gb_clk    = 1'b0;
    logic           gb_arst_n = 1'b1;
    logic           start     = 1'b0;
    logic           abort     = 1'b0;
    logic [1:0]     mode      = '0;
    logic [AW-1:0]  base_addr = '0;
    logic [AW-1:0]  count     = '0;
    logic [DW-1:0]  seed      = '0;
    logic [DW-1:0]  dmask     = '0;
    logic           busy;
    logic           done;
    logic           pass;
    logic [ECW-1:0] err_count;
    logic [AW-1:0]  first_err_addr;
    logic [DW-1:0]  first_err_data;
    logic [AW-1:0]  gb_addr;
    logic [DW-1:0]  gb_wdata;
    logic           gb_wen;
    logic           gb_rstb;
    logic [DW-1:0]  gb_rdata;

    gb_bist_master #(
        .AW(AW),
        .DW(DW),
        .RD_LAT(RD_LAT),
        .ECW(ECW)
    ) dut (
        .gb_clk(gb_clk),
        .gb_arst_n(gb_arst_n),
        .start(start),
        .abort(abort),
        .mode(mode),
        .base_addr(base_addr),
        .count(count),
        .seed(seed),
        .dmask(dmask),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .gb_addr(gb_addr),
        .gb_wdata(gb_wdata),
        .gb_wen(gb_wen),
        .gb_rstb(gb_rstb),
        .gb_rdata(gb_rdata)
    );

    always #5 gb_clk = ~gb_clk;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- RAM slave ----------------
    logic [DW-1:0] ram   [logic [AW-1:0]];
    logic [DW-1:0] fault [logic [AW-1:0]];
    logic          pv [RD_LAT] = '{default: 1'b0};
    logic [DW-1:0] pd [RD_LAT] = '{default: '0};
    logic [DW-1:0] junk = '0;

    function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = ram.exists(a) ? ram[a] : '0;
        if (fault.exists(a)) v = v ^ fault[a];
        return v;
    endfunction

    always @(posedge gb_clk) begin
        if (gb_wen) ram[gb_addr] = gb_wdata;
        pv[0] <= gb_rstb;
        pd[0] <= slave_rd(gb_addr);
        for (int k = 1; k < RD_LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
        junk <= $urandom;
    end

    assign gb_rdata = pv[RD_LAT-1] ? pd[RD_LAT-1] : junk;

    // ---------------- reference model ----------------
    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int unsigned   t;
    } ev_t;

    typedef struct {
        int unsigned   err;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
        bit            ok;
        int unsigned   t;
    } res_t;

    logic [DW-1:0] mdl [logic [AW-1:0]];
    ev_t  exp_bus [$];
    res_t exp_res [$];

    function automatic void predict(input logic [1:0] m, input logic [AW-1:0] b,
                                    input logic [AW-1:0] c, input logic [DW-1:0] s,
                                    input logic [DW-1:0] dm);
        bit            do_w;
        bit            do_r;
        int unsigned   t;
        ev_t           e;
        res_t          r;
        logic [DW-1:0] rd;
        logic [DW-1:0] want;
        do_w = (m == 2'd0) || (m == 2'd2);
        do_r = (m != 2'd0);
        t = 1;
        r.err = 0; r.fa = '0; r.fd = '0;
        if (do_w) begin
            for (int unsigned i = 0; i < c; i++) begin
                e.wr = 1'b1; e.a = b + AW'(i); e.d = s + DW'(i); e.t = t;
                exp_bus.push_back(e);
                mdl[e.a] = e.d;
                t++;
            end
        end
        if (do_r) begin
            for (int unsigned i = 0; i < c; i++) begin
                e.wr = 1'b0; e.a = b + AW'(i); e.d = '0; e.t = t;
                exp_bus.push_back(e);
                rd = mdl.exists(e.a) ? mdl[e.a] : '0;
                if (fault.exists(e.a)) rd = rd ^ fault[e.a];
                want = s + DW'(i);
                if (((rd ^ want) & dm) != '0) begin
                    if (r.err == 0) begin
                        r.fa = e.a;
                        r.fd = rd;
                    end
                    if (r.err < (2 ** ECW) - 1) r.err++;
                end
                t += RD_LAT + 1;
            end
        end
        r.ok = (r.err == 0);
        r.t  = t;
        exp_res.push_back(r);
    endfunction

    // ---------------- monitor ----------------
    int unsigned cyc     = 0;
    int unsigned t0      = 0;
    bit          pending = 1'b0;

    always @(negedge gb_clk) begin
        ev_t         e;
        res_t        r;
        int unsigned rel;
        cyc++;
        rel = cyc - t0;
        if (gb_arst_n) begin
            if (gb_wen || gb_rstb) begin
                chk("strobe_excl", {63'd0, gb_wen & gb_rstb}, 64'd0);
                if (exp_bus.size() == 0) begin
                    chk("unexpected_strobe", {62'd0, gb_wen, gb_rstb}, 64'd0);
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus_kind", {63'd0, gb_wen}, {63'd0, e.wr});
                    chk("bus_addr", 64'(gb_addr), 64'(e.a));
                    if (e.wr) chk("bus_wdata", 64'(gb_wdata), 64'(e.d));
                    chk("bus_cycle", 64'(rel), 64'(e.t));
                end
            end
            if (pending && done) begin
                pending = 1'b0;
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    r = exp_res.pop_front();
                    chk("err_count", 64'(err_count), 64'(r.err));
                    chk("first_err_addr", 64'(first_err_addr), 64'(r.fa));
                    chk("first_err_data", 64'(first_err_data), 64'(r.fd));
                    chk("pass", {63'd0, pass}, {63'd0, r.ok});
                    chk("done_cycle", 64'(rel), 64'(r.t));
                    chk("busy_at_done", {63'd0, busy}, 64'd0);
                    chk("bus_events_left", 64'(exp_bus.size()), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW-1:0] c,
                         input logic [DW-1:0] s, input logic [DW-1:0] dm, input bit acc);
        @(posedge gb_clk); #1;
        start = 1'b1; mode = m; base_addr = b; count = c; seed = s; dmask = dm;
        if (acc) predict(m, b, c, s, dm);
        @(posedge gb_clk); #1;
        start = 1'b0;
        // Scramble the config so any late sampling shows up.
        mode = 2'($urandom); base_addr = AW'($urandom); count = AW'($urandom);
        seed = $urandom; dmask = $urandom;
        if (acc) begin
            t0 = cyc;
            pending = 1'b1;
        end
    endtask

    task automatic flush_run();
        exp_bus.delete();
        exp_res.delete();
        pending = 1'b0;
        mdl = ram;
    endtask

    task automatic wait_done(input string name);
        int unsigned n;
        n = 0;
        while (pending && (n < 3000)) begin
            @(negedge gb_clk);
            n++;
        end
        if (pending) begin
            chk({name, "_timeout"}, {63'd0, pending}, 64'd0);
            flush_run();
        end
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge gb_clk); #1;
        abort = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, pending=%0d", pending);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    m;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
        logic [DW-1:0] dm;

        // Reset state.
        #2 gb_arst_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_pass", {63'd0, pass}, 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_gb_wen", {63'd0, gb_wen}, 64'd0);
        chk("rst_gb_rstb", {63'd0, gb_rstb}, 64'd0);
        chk("rst_gb_addr", 64'(gb_addr), 64'd0);
        repeat (3) @(posedge gb_clk);
        #1 gb_arst_n = 1'b1;
        repeat (3) @(posedge gb_clk);

        // 1: clean mode-2 run.
        issue(2'd2, 24'h000100, 24'd4, 32'hA5A50000, '1, 1'b1);
        wait_done("t1");
        chk("t1_pass", {63'd0, pass}, 64'd1);
        chk("t1_err", 64'(err_count), 64'd0);

        // 2: bit0 of word 2 forced by the slave.
        fault[24'h000102] = 32'h1;
        issue(2'd2, 24'h000100, 24'd4, 32'hA5A50000, '1, 1'b1);
        wait_done("t2");
        chk("t2_err", 64'(err_count), 64'd1);
        chk("t2_fea", 64'(first_err_addr), 64'h102);
        chk("t2_fed", 64'(first_err_data), 64'hA5A50003);
        chk("t2_pass", {63'd0, pass}, 64'd0);
        issue(2'd2, 24'h000100, 24'd4, 32'hA5A50000, 32'hFFFFFFFE, 1'b1);
        wait_done("t2m");
        chk("t2m_pass", {63'd0, pass}, 64'd1);

        // Abort after a logged error: error log survives, status clears.
        issue(2'd1, 24'h000102, 24'd8, 32'hA5A50002, '1, 1'b1);
        repeat (4) begin
            @(posedge gb_clk); #1;
        end
        pulse_abort();
        chk("ab1_err", 64'(err_count), 64'd1);
        chk("ab1_fea", 64'(first_err_addr), 64'h102);
        chk("ab1_fed", 64'(first_err_data), 64'hA5A50003);
        chk("ab1_done", {63'd0, done}, 64'd0);
        chk("ab1_busy", {63'd0, busy}, 64'd0);
        chk("ab1_rstb", {63'd0, gb_rstb}, 64'd0);
        flush_run();
        fault.delete();

        // 3: address wrap.
        issue(2'd2, 24'hFFFFFE, 24'd4, $urandom, '1, 1'b1);
        wait_done("t3");

        // 4: empty window.
        issue(2'd2, 24'h000010, 24'd0, $urandom, '1, 1'b1);
        wait_done("t4");
        chk("t4_busy", {63'd0, busy}, 64'd0);

        // 5: abort three cycles into a 16-word run.
        issue(2'd2, 24'h000300, 24'd16, $urandom, '1, 1'b1);
        repeat (2) begin
            @(posedge gb_clk); #1;
        end
        pulse_abort();
        chk("ab2_wen", {63'd0, gb_wen}, 64'd0);
        chk("ab2_rstb", {63'd0, gb_rstb}, 64'd0);
        chk("ab2_done", {63'd0, done}, 64'd0);
        chk("ab2_pass", {63'd0, pass}, 64'd0);
        chk("ab2_busy", {63'd0, busy}, 64'd0);
        flush_run();
        repeat (4) @(posedge gb_clk);

        // 5b: a start while busy is ignored.
        issue(2'd2, 24'h000400, 24'd3, $urandom, '1, 1'b1);
        issue(2'd1, 24'h000500, 24'd5, $urandom, '1, 1'b0);
        wait_done("t5b");

        // 6: async reset during WAIT, then a fresh read-check run.
        issue(2'd1, 24'h000100, 24'd4, 32'hA5A50000, '1, 1'b1);
        @(posedge gb_clk); #2;
        gb_arst_n = 1'b0;
        #1;
        chk("ar_busy", {63'd0, busy}, 64'd0);
        chk("ar_rstb", {63'd0, gb_rstb}, 64'd0);
        chk("ar_wen", {63'd0, gb_wen}, 64'd0);
        chk("ar_addr", 64'(gb_addr), 64'd0);
        chk("ar_wdata", 64'(gb_wdata), 64'd0);
        chk("ar_err", 64'(err_count), 64'd0);
        chk("ar_fea", 64'(first_err_addr), 64'd0);
        chk("ar_fed", 64'(first_err_data), 64'd0);
        chk("ar_done", {63'd0, done}, 64'd0);
        chk("ar_pass", {63'd0, pass}, 64'd0);
        flush_run();
        repeat (2) @(posedge gb_clk);
        #1 gb_arst_n = 1'b1;
        repeat (3) @(posedge gb_clk);
        issue(2'd1, 24'h000100, 24'd4, 32'hA5A50000, '1, 1'b1);
        wait_done("t6");
        chk("t6_pass", {63'd0, pass}, 64'd1);

        // Randomized runs.
        for (int k = 0; k < 25; k++) begin
            m = 2'($urandom_range(0, 3));
            b = (($urandom_range(0, 1) != 0) ? 24'hFFFFF8 : 24'h000200) + AW'($urandom_range(0, 15));
            c = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 1) != 0) dm = '1;
            else dm = $urandom;
            fault.delete();
            if ($urandom_range(0, 1) != 0) begin
                fault[b + AW'($urandom_range(0, 7))] = DW'(1) << $urandom_range(0, DW - 1);
            end
            issue(m, b, c, $urandom, dm, 1'b1);
            wait_done("rnd");
        end

        repeat (3) @(posedge gb_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
